// File: rtl/deser_mem_writer_pkg.sv
// Shared constants for the serial-to-memory writer and its matching transmitter.
package deser_mem_writer_pkg;

  localparam int DMW_DATA_W = 8;
  localparam int DMW_DEPTH  = 16;
  localparam int DMW_ADDR_W = 4;
  localparam int DMW_CNT_W  = 3;

  // Next write address, wrapping from the last word back to word 0.
  function automatic logic [DMW_ADDR_W-1:0] next_wr_addr(input logic [DMW_ADDR_W-1:0] addr);
    logic [DMW_ADDR_W-1:0] nxt;
    if (addr == DMW_ADDR_W'(DMW_DEPTH - 1)) begin
      nxt = {DMW_ADDR_W{1'b0}};
    end else begin
      nxt = addr + DMW_ADDR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/deser_mem_writer_bit_assembler.sv
// Collects serial bits (LSB first) into a word; flags the edge that completes it.
module deser_mem_writer_bit_assembler
  import deser_mem_writer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_sin,
  input  logic                  i_sin_valid,
  input  logic                  i_sync,
  output logic [DMW_DATA_W-1:0] o_word,
  output logic                  o_word_complete,
  output logic [DMW_CNT_W-1:0]  o_bit_cnt
);

  // Only the lower seven bits need storage; bit 7 is taken straight from sin.
  logic [DMW_DATA_W-2:0] r_shreg;
  logic [DMW_CNT_W-1:0]  r_bit_cnt;
  logic [DMW_DATA_W-2:0] w_shreg_nxt;
  logic [DMW_CNT_W-1:0]  w_bit_cnt_nxt;
  logic [DMW_DATA_W-2:0] w_sin_at_pos;
  logic                  w_last_bit;

  assign w_last_bit   = (r_bit_cnt == DMW_CNT_W'(DMW_DATA_W - 1));
  assign w_sin_at_pos = {{(DMW_DATA_W-2){1'b0}}, i_sin} << r_bit_cnt;

  // Next bit position and shift contents; sync outranks word completion.
  always_comb begin
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    if (i_sync) begin
      if (i_sin_valid) begin
        w_shreg_nxt   = {{(DMW_DATA_W-2){1'b0}}, i_sin};
        w_bit_cnt_nxt = DMW_CNT_W'(1);
      end else begin
        w_shreg_nxt   = {(DMW_DATA_W-1){1'b0}};
        w_bit_cnt_nxt = {DMW_CNT_W{1'b0}};
      end
    end else if (i_sin_valid) begin
      if (w_last_bit) begin
        // Word leaves through o_word this edge; start the next one clean.
        w_shreg_nxt = {(DMW_DATA_W-1){1'b0}};
      end else begin
        w_shreg_nxt = r_shreg | w_sin_at_pos;
      end
      w_bit_cnt_nxt = r_bit_cnt + DMW_CNT_W'(1);
    end else begin
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
    end
  end

  // Bit counter and shift register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg   <= {(DMW_DATA_W-1){1'b0}};
      r_bit_cnt <= {DMW_CNT_W{1'b0}};
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  assign o_word          = {i_sin, r_shreg};
  assign o_word_complete = i_sin_valid & ~i_sync & w_last_bit;
  assign o_bit_cnt       = r_bit_cnt;

endmodule

// File: rtl/deser_mem_writer.sv
// Deserialises a bit stream into a circular word memory with a combinational read port.
module deser_mem_writer
  import deser_mem_writer_pkg::*;
#(
  parameter int DATA_W = DMW_DATA_W,
  parameter int DEPTH  = DMW_DEPTH,
  parameter int ADDR_W = DMW_ADDR_W
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_sin,
  input  logic              i_sin_valid,
  input  logic              i_sync,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [2:0]        o_bit_cnt,
  output logic              o_byte_done,
  output logic              o_wrap
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_byte_done;
  logic              r_wrap;
  logic [DATA_W-1:0] w_word;
  logic              w_word_complete;
  logic              w_last_addr;

  deser_mem_writer_bit_assembler u_bit_assembler (
    .clock           (clock),
    .reset           (reset),
    .i_sin           (i_sin),
    .i_sin_valid     (i_sin_valid),
    .i_sync          (i_sync),
    .o_word          (w_word),
    .o_word_complete (w_word_complete),
    .o_bit_cnt       (o_bit_cnt)
  );

  assign w_last_addr = (r_wr_addr == ADDR_W'(DEPTH - 1));

  // Memory array: cleared on reset, written on the edge that completes a word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_word_complete) begin
      r_mem[r_wr_addr] <= w_word;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Write pointer: advances per word and overwrites the oldest entry on wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_addr <= {ADDR_W{1'b0}};
    end else if (w_word_complete) begin
      r_wr_addr <= next_wr_addr(r_wr_addr);
    end else begin
      r_wr_addr <= r_wr_addr;
    end
  end

  // One-cycle status pulses following a write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_done <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_byte_done <= w_word_complete;
      r_wrap      <= w_word_complete & w_last_addr;
    end
  end

  assign o_rd_data   = r_mem[i_rd_addr];
  assign o_wr_addr   = r_wr_addr;
  assign o_byte_done = r_byte_done;
  assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_deser_mem_writer.sv
// Randomised and directed bench for deser_mem_writer against a bit-queue reference model.
module tb_deser_mem_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic [3:0] wr_addr;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       wrap;

  deser_mem_writer dut (
    .clock       (clock),
    .reset       (reset),
    .i_sin       (sin),
    .i_sin_valid (sin_valid),
    .i_sync      (sync),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_wr_addr   (wr_addr),
    .o_bit_cnt   (bit_cnt),
    .o_byte_done (byte_done),
    .o_wrap      (wrap)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int wrap_cnt = 0;

  // Reference model: bits of the current word kept as a queue, memory as plain ints.
  int m_mem [16];
  int m_wa;
  int m_bits [$];
  int m_exp_done;
  int m_exp_wrap;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_mem[a] = 0;
    m_wa = 0;
    m_bits.delete();
    m_exp_done = 0;
    m_exp_wrap = 0;
  endtask

  task automatic model_edge(input int v, input int s, input int b);
    int w;
    m_exp_done = 0;
    m_exp_wrap = 0;
    if (s != 0) begin
      m_bits.delete();
      if (v != 0) m_bits.push_back(b);
    end else if (v != 0) begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) begin
        w = 0;
        for (int i = 0; i < 8; i++) w += m_bits[i] * (1 << i);
        m_mem[m_wa] = w;
        m_exp_done = 1;
        m_exp_wrap = (m_wa == 15) ? 1 : 0;
        m_wa = (m_wa + 1) % 16;
        m_bits.delete();
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".bit_cnt"}, bit_cnt, m_bits.size());
    check({tag, ".wr_addr"}, wr_addr, m_wa);
    check({tag, ".byte_done"}, byte_done, m_exp_done);
    check({tag, ".wrap"}, wrap, m_exp_wrap);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      check($sformatf("%s.mem[%0d]", tag, a), rd_data, m_mem[a]);
    end
  endtask

  task automatic cycle(input int v, input int s, input int b, input string tag);
    sin_valid = (v != 0);
    sync      = (s != 0);
    sin       = (b != 0);
    @(posedge clock);
    #1;
    model_edge(v, s, b);
    check_state(tag);
    if (byte_done) done_cnt++;
    if (wrap) wrap_cnt++;
    sin_valid = 1'b0;
    sync      = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic send_bits(input int word, input int n, input int start, input string tag);
    for (int i = start; i < start + n; i++) cycle(1, 0, (word >> i) & 1, tag);
  endtask

  // Asynchronous reset mid-cycle; valid/sync toggled while low must be ignored.
  task automatic apply_reset(input int ncyc, input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state({tag, ".now"});
    check_mem({tag, ".now"});
    sin_valid = 1'b1;
    sync      = 1'b1;
    sin       = 1'b1;
    repeat (ncyc) @(posedge clock);
    #1;
    check_state({tag, ".held"});
    sin_valid = 1'b0;
    sync      = 1'b0;
    sin       = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    done_cnt = 0;
    wrap_cnt = 0;
  endtask

  initial begin
    int base;
    model_reset();
    repeat (5) @(posedge clock);
    #1;
    check_state("por");
    check_mem("por");
    @(negedge clock);
    reset = 1'b1;

    // Single word 0xCC.
    send_bits(8'hCC, 8, 0, "cc");
    check("cc.pulses", done_cnt, 1);
    check("cc.wr_addr", wr_addr, 1);
    rd_addr = 4'd0;
    #1;
    check("cc.mem0", rd_data, 8'hCC);

    // Sixteen back-to-back words fill and wrap the memory.
    apply_reset(2, "r1");
    for (int w = 0; w < 16; w++) send_bits((w % 2) ? 8'hAA : 8'hCC, 8, 0, "fill");
    check("fill.pulses", done_cnt, 16);
    check("fill.wraps", wrap_cnt, 1);
    check("fill.wr_addr", wr_addr, 0);
    rd_addr = 4'd6;
    #1;
    check("fill.even", rd_data, 8'hCC);
    rd_addr = 4'd15;
    #1;
    check("fill.odd", rd_data, 8'hAA);
    check_mem("fill");

    // Gap in sin_valid mid-word.
    apply_reset(1, "r2");
    send_bits(8'h5A, 3, 0, "gap.a");
    repeat (4) begin
      cycle(0, 0, 0, "gap.idle");
      check("gap.hold", bit_cnt, 3);
    end
    send_bits(8'h5A, 5, 3, "gap.b");
    check("gap.pulses", done_cnt, 1);
    rd_addr = 4'd0;
    #1;
    check("gap.mem0", rd_data, 8'h5A);

    // Sync with a valid bit after 4 bits, then sync on the completing edge.
    apply_reset(1, "r3");
    send_bits(8'h00, 4, 0, "sync.a");
    cycle(1, 1, 1, "sync.edge");
    check("sync.cnt", bit_cnt, 1);
    send_bits(8'hB5, 7, 1, "sync.b");
    check("sync.pulses", done_cnt, 1);
    rd_addr = 4'd0;
    #1;
    check("sync.mem0", rd_data, 8'hB5);
    send_bits(8'hFF, 7, 0, "sync.c");
    cycle(1, 1, 0, "sync.last");
    check("sync.prio_pulses", done_cnt, 1);
    check("sync.prio_addr", wr_addr, 1);
    check_mem("sync");

    // Reset in the middle of the second word.
    apply_reset(1, "r4");
    send_bits(8'h11, 8, 0, "mid.w1");
    send_bits(8'h22, 5, 0, "mid.w2");
    check("mid.cnt", bit_cnt, 5);
    apply_reset(3, "r5");
    send_bits(8'hAA, 8, 0, "mid.aa");
    rd_addr = 4'd0;
    #1;
    check("mid.mem0", rd_data, 8'hAA);

    // Read-during-write at the address being written.
    apply_reset(1, "r6");
    send_bits(8'h3C, 7, 0, "rdw");
    rd_addr = m_wa[3:0];
    #1;
    check("rdw.before", rd_data, 8'h00);
    cycle(1, 0, 0, "rdw.edge");
    check("rdw.after", rd_data, 8'h3C);

    // Randomised stream with occasional sync and gaps.
    apply_reset(1, "r7");
    base = 0;
    repeat (400) begin
      cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            $urandom_range(0, 1), "rnd");
      rd_addr = 4'($urandom_range(0, 15));
      #1;
      check("rnd.rd_data", rd_data, m_mem[rd_addr]);
      base++;
    end
    check("rnd.cycles", base, 400);
    check_mem("rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/deser_mem_writer.md
DESER_MEM_WRITER -- requirements
Module: deser_mem_writer

Interface
REQ-001 Parameter DATA_W, 8, bits per word (fixed at 8 for this revision).
REQ-002 Parameter DEPTH, 16, number of memory words.
REQ-003 Parameter ADDR_W, 4, address width, equal to log2(DEPTH).
REQ-004 clock  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 sin  input  1  serial data bit, LSB of each word first.
REQ-007 sin_valid  input  1  sin is sampled on this edge when high.
REQ-008 sync  input  1  frame realign; discards the partial word.
REQ-009 rd_addr  input  ADDR_W  read address for inspection.
REQ-010 rd_data  output  DATA_W  combinational read, mem[rd_addr].
REQ-011 wr_addr  output  ADDR_W  address the next completed word is written to.
REQ-012 bit_cnt  output  3  bit position of the next accepted bit.
REQ-013 byte_done  output  1  single-cycle pulse after a word is written.
REQ-014 wrap  output  1  single-cycle pulse after the word at address DEPTH-1 is written.

Function
REQ-015 The block SHALL, on each edge with sin_valid=1, store sin at shift-register bit index bit_cnt and increment bit_cnt modulo 8.
REQ-016 The block SHALL, with sin_valid=0 and sync=0, hold bit_cnt, the shift register, wr_addr and memory unchanged.
REQ-017 The block SHALL, on the edge accepting bit_cnt=7, write {sin, shreg[6:0]} into mem[wr_addr] on that same edge, with zero extra latency.
REQ-018 The block SHALL increment wr_addr on each write, wrapping from DEPTH-1 to 0 and overwriting the oldest data, with no full stall.
REQ-019 The block SHALL register byte_done high for exactly the one cycle following a write edge; back-to-back words SHALL give pulses 8 valid edges apart.
REQ-020 The block SHALL register wrap high for one cycle, coincident with byte_done, when the write went to address DEPTH-1.
REQ-021 The block SHALL, with sync=1 and sin_valid=0, clear bit_cnt to 0 and discard the partial word, leaving memory and wr_addr unchanged.
REQ-022 The block SHALL, with sync=1 and sin_valid=1, discard the partial word, take sin as bit 0 and set bit_cnt to 1; sync has priority over completion, so no write occurs.
REQ-023 The block SHALL drive rd_data combinationally from memory; when rd_addr equals the written address, rd_data SHALL show the old value before the edge and the new value after it.
REQ-024 The block SHALL be bit-order compatible with a transmitter that emits word bits 0..7 in order, one per clock, and advances the address every 8 clocks.

Reset
REQ-025 The block SHALL, while reset=0, asynchronously force bit_cnt=0, shift register=0, wr_addr=0, byte_done=0, wrap=0 and all memory words to 8'h00.
REQ-026 The block SHALL discard any partial word on reset assertion mid-word; the first valid bit after release SHALL be bit 0 of the word at address 0.
REQ-027 The block SHALL ignore sin_valid and sync on an edge where reset is low.

Structure
REQ-028 DATA_W, DEPTH and ADDR_W SHALL be defined in a shared package that the matching transmitter also uses.
REQ-029 bit_cnt and the shift register SHALL be in one sub-module, bit_assembler, which outputs the assembled word and a word_complete strobe.
REQ-030 The memory array and wr_addr counter SHALL reside in deser_mem_writer; no other sub-modules.

Verification
REQ-031 Reset low 5 cycles, then release; stream 0xCC as bits 0,0,1,1,0,0,1,1 -> mem[0]=0xCC, one byte_done pulse, wr_addr=1.
REQ-032 Stream 16 words alternating 0xCC/0xAA continuously -> mem[even]=0xCC, mem[odd]=0xAA, wrap pulses once after word 16, wr_addr=0.
REQ-033 Send 3 bits, drop sin_valid 4 cycles, then send 5 bits of 0x5A -> single write of 0x5A, bit_cnt holds at 3 during the gap.
REQ-034 Send 4 bits, assert sync with sin_valid=1 and bit=1, then 7 more bits -> no write at the sync edge; word has bit0=1 and is written after 8 total bits.
REQ-035 Assert reset at bit_cnt=5 of word 2 -> all outputs and memory are 0 immediately; the next stream of 0xAA lands at mem[0].
REQ-036 Hold rd_addr=wr_addr across a write of 0x3C over 0x00 -> rd_data is 0x00 before the edge and 0x3C after it.
